// File: rtl/switch_output_arbiter.sv
// rtl/switch_output_arbiter.sv - round-robin output-port arbiter with frame hold, oversize detect and frame count
module switch_output_arbiter #(
  parameter int RADIX     = 4,
  parameter int MAX_BEATS = 2048,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [RADIX-1:0]         req,
  input  logic [RADIX-1:0]         enable,
  input  logic                     m_valid,
  input  logic                     m_ready,
  input  logic                     m_last,
  output logic [RADIX-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(RADIX)-1:0] grant_index,
  output logic                     oversize,
  output logic [CNT_WIDTH-1:0]     frame_count
);

  localparam int IW = $clog2(RADIX);
  localparam int BW = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state;
  logic [IW-1:0]  ptr;
  logic [BW-1:0]  beat_cnt;
  logic [1:0]     rst_sync;
  logic           run;
  logic [RADIX-1:0] eligible;
  logic           pick_found;
  logic [IW-1:0]  pick_idx;
  logic [IW:0]    cand;
  logic           beat;

  // Reset asserts asynchronously but arbitration resumes only once release has crossed two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run = rst_sync[1];

  assign eligible = req & enable;
  assign beat     = m_valid & m_ready;

  // Search starts one past the last winner, so the just-finished input is examined last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < RADIX; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k) + (IW+1)'(1);
      if (cand >= (IW+1)'(RADIX)) cand = cand - (IW+1)'(RADIX);
      if (!pick_found && eligible[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_index <= '0;
      ptr         <= IW'(RADIX - 1);
      beat_cnt    <= '0;
      oversize    <= 1'b0;
      frame_count <= '0;
    end else begin
      oversize <= 1'b0;
      if (run) begin
        case (state)
          IDLE: begin
            beat_cnt <= '0;
            if (pick_found) begin
              grant       <= {{(RADIX-1){1'b0}}, 1'b1} << pick_idx;
              grant_valid <= 1'b1;
              grant_index <= pick_idx;
              ptr         <= pick_idx;
              state       <= BUSY;
            end
          end
          BUSY: begin
            if (beat && m_last) begin
              if (frame_count != '1) frame_count <= frame_count + 1'b1;
              beat_cnt <= '0;
              if (pick_found) begin
                grant       <= {{(RADIX-1){1'b0}}, 1'b1} << pick_idx;
                grant_index <= pick_idx;
                ptr         <= pick_idx;
              end else begin
                grant       <= '0;
                grant_valid <= 1'b0;
                grant_index <= '0;
                state       <= IDLE;
              end
            end else if (beat) begin
              // Counter parks at MAX_BEATS so the pulse fires once per frame.
              if (beat_cnt != BW'(MAX_BEATS)) beat_cnt <= beat_cnt + 1'b1;
              if (beat_cnt == BW'(MAX_BEATS - 1)) oversize <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_switch_output_arbiter.sv
// tb/tb_switch_output_arbiter.sv - directed table and sequence bench for switch_output_arbiter
module tb_switch_output_arbiter;

  localparam int RADIX = 4;
  localparam int MAX_BEATS = 8;
  localparam int CNT_WIDTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, enable;
  logic       m_valid, m_ready, m_last;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_index;
  logic       oversize;
  logic [3:0] frame_count;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  switch_output_arbiter #(.RADIX(RADIX), .MAX_BEATS(MAX_BEATS), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .enable(enable),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .grant(grant), .grant_valid(grant_valid), .grant_index(grant_index),
    .oversize(oversize), .frame_count(frame_count)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] en;
    logic       mv, mr, ml;
    logic [3:0] g;
    logic       gv;
    logic [1:0] idx;
    logic       ov;
    logic [3:0] fc;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic gv,
                         input logic [1:0] idx, input logic ov, input logic [3:0] fc);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(gv));
    chk({tag, ".grant_index"}, 32'(grant_index), 32'(idx));
    chk({tag, ".oversize"}, 32'(oversize), 32'(ov));
    chk({tag, ".frame_count"}, 32'(frame_count), 32'(fc));
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] e,
                      input logic v, input logic rd, input logic l);
    req = r; enable = e; m_valid = v; m_ready = rd; m_last = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rotation, multi-beat hold with stalls, drain to idle, enable drop mid-frame
    tbl[0]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 4'd0};
    tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 4'd1};
    tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 4'd2};
    tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 4'd3};
    tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 4'd4};
    tbl[5]  = '{4'b0101, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 4'd4};
    tbl[6]  = '{4'b0101, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 4'd4};
    tbl[7]  = '{4'b0101, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 4'd4};
    tbl[8]  = '{4'b0101, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 4'd4};
    tbl[9]  = '{4'b0101, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 4'd4};
    tbl[10] = '{4'b0101, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 4'd4};
    tbl[11] = '{4'b0101, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 4'd4};
    tbl[12] = '{4'b0101, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 4'd5};
    tbl[13] = '{4'b0101, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 4'd6};
    tbl[14] = '{4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 4'd7};
    tbl[15] = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'd7};
    tbl[16] = '{4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 4'd7};
    tbl[17] = '{4'b0001, 4'b1110, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 4'd7};
    tbl[18] = '{4'b0000, 4'b1110, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 4'd8};

    rst_n = 1'b0; req = '0; enable = '0; m_valid = 0; m_ready = 0; m_last = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 4'b0000, 1'b0, 2'd0, 1'b0, 4'd0);
    rst_n = 1'b1;
    step(4'b1111, 4'b1111, 0, 0, 0);
    chk("sync_edge1.grant_valid", 32'(grant_valid), 32'd0);
    step(4'b1111, 4'b1111, 0, 0, 0);
    chk("sync_edge2.grant_valid", 32'(grant_valid), 32'd0);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].req, tbl[i].en, tbl[i].mv, tbl[i].mr, tbl[i].ml);
      chk_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].gv, tbl[i].idx, tbl[i].ov, tbl[i].fc);
    end

    // disabled requester is never granted until its enable returns
    for (int i = 0; i < 20; i++) begin
      step(4'b0010, 4'b1101, 0, 0, 0);
      chk($sformatf("disabled%0d.grant_valid", i), 32'(grant_valid), 32'd0);
    end
    step(4'b0010, 4'b1111, 0, 0, 0);
    chk_out("enable1", 4'b0010, 1'b1, 2'd1, 1'b0, 4'd8);
    step(4'b0000, 4'b1111, 1, 1, 1);
    chk_out("enable1_done", 4'b0000, 1'b0, 2'd0, 1'b0, 4'd9);

    // 12-beat frame against MAX_BEATS=8
    step(4'b0001, 4'b1111, 0, 0, 0);
    chk_out("big_grant", 4'b0001, 1'b1, 2'd0, 1'b0, 4'd9);
    for (int b = 1; b <= 12; b++) begin
      step(4'b0000, 4'b1111, 1, 1, (b == 12));
      if (b < 12) chk_out($sformatf("big_beat%0d", b), 4'b0001, 1'b1, 2'd0, (b == 8), 4'd9);
      else        chk_out("big_end", 4'b0000, 1'b0, 2'd0, 1'b0, 4'd10);
    end

    // asynchronous reset in the middle of beat 3
    step(4'b0001, 4'b1111, 0, 0, 0);
    chk_out("rst_frame_grant", 4'b0001, 1'b1, 2'd0, 1'b0, 4'd10);
    step(4'b0001, 4'b1111, 1, 1, 0);
    step(4'b0001, 4'b1111, 1, 1, 0);
    m_valid = 1; m_ready = 1; m_last = 0;
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 4'b0000, 1'b0, 2'd0, 1'b0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_out("rst_held", 4'b0000, 1'b0, 2'd0, 1'b0, 4'd0);
    rst_n = 1'b1;
    step(4'b1111, 4'b1111, 0, 0, 0);
    chk("rerelease1.grant_valid", 32'(grant_valid), 32'd0);
    step(4'b1111, 4'b1111, 0, 0, 0);
    chk("rerelease2.grant_valid", 32'(grant_valid), 32'd0);
    step(4'b0001, 4'b1111, 0, 0, 0);
    chk_out("restart", 4'b0001, 1'b1, 2'd0, 1'b0, 4'd0);

    // frame counter saturation at 4 bits
    for (int n = 1; n <= 20; n++) begin
      step(4'b0001, 4'b1111, 1, 1, 1);
      chk_out($sformatf("sat%0d", n), 4'b0001, 1'b1, 2'd0, 1'b0, (n > 15) ? 4'd15 : 4'(n));
    end
    step(4'b0000, 4'b1111, 1, 1, 1);
    chk_out("sat_end", 4'b0000, 1'b0, 2'd0, 1'b0, 4'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
